// File: rtl/alu_result_if.sv
// alu_result_if: handshake/bus bundle between the ALU, the result stage and
// writeback.
//   master : ALU/writeback side (drives push-side data, Flush, OutReady)
//   slave  : the result stage (drives InReady, head outputs, Flags, OpCount)
interface alu_result_if #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3
);
    logic                InValid;
    logic                InReady;
    logic [WIDTH-1:0]    Result;
    logic                Zero;
    logic                Overflow;
    logic                CarryOut;
    logic [REG_BITS-1:0] RegDst;
    logic                RegWrite;
    logic                FlagWrite;
    logic                Flush;
    logic                OutValid;
    logic                OutReady;
    logic [WIDTH-1:0]    OutData;
    logic [REG_BITS-1:0] OutRegDst;
    logic                OutRegWrite;
    logic [3:0]          Flags;
    logic [15:0]         OpCount;

    modport master (
        output InValid, Result, Zero, Overflow, CarryOut, RegDst, RegWrite,
               FlagWrite, Flush, OutReady,
        input  InReady, OutValid, OutData, OutRegDst, OutRegWrite, Flags, OpCount
    );

    modport slave (
        input  InValid, Result, Zero, Overflow, CarryOut, RegDst, RegWrite,
               FlagWrite, Flush, OutReady,
        output InReady, OutValid, OutData, OutRegDst, OutRegWrite, Flags, OpCount
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered EX-to-writeback stage behind the ALU.
// Buffers {Result, RegDst, RegWrite} in a 2-entry in-order FIFO, presents the
// head to writeback over valid/ready, keeps the {N,Z,C,V} flags and counts
// retired (popped) operations.
// Ports:
//   Clock - rising-edge clock
//   Reset - synchronous, active-high reset
//   bus   - alu_result_if.slave: push side (InValid/InReady, Result, flags in,
//           RegDst, RegWrite, FlagWrite), Flush, pop side (OutValid/OutReady,
//           OutData, OutRegDst, OutRegWrite), Flags, OpCount
module alu_result_stage #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3
) (
    input  logic        Clock,
    input  logic        Reset,
    alu_result_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0]    data;
        logic [REG_BITS-1:0] dst;
        logic                wr;
    } entry_t;

    entry_t      mem [2];
    entry_t      head, head_n, in_e;
    logic        rptr, wptr, rptr_n, wptr_n;
    logic [1:0]  count, cnt_n;
    logic [3:0]  flags;
    logic [15:0] ops;
    logic        push, pop;

    assign bus.InReady     = (count < 2'd2);
    assign bus.OutValid    = (count != 2'd0);
    assign bus.OutData     = head.data;
    assign bus.OutRegDst   = head.dst;
    assign bus.OutRegWrite = head.wr;
    assign bus.Flags       = flags;
    assign bus.OpCount     = ops;

    // Flush drops a same-cycle push entirely (no store, no flag update),
    // while a same-cycle pop still completes.
    assign push = bus.InValid & bus.InReady & ~bus.Flush;
    assign pop  = bus.OutValid & bus.OutReady;

    always_comb begin
        in_e = '{data: bus.Result, dst: bus.RegDst, wr: bus.RegWrite};
    end

    always_comb begin
        cnt_n  = count;
        rptr_n = rptr;
        wptr_n = wptr;
        head_n = head;
        if (push && !pop)
            cnt_n = count + 2'd1;
        else if (pop && !push)
            cnt_n = count - 2'd1;
        if (push) wptr_n = ~wptr;
        if (pop)  rptr_n = ~rptr;
        if (bus.Flush) begin
            cnt_n  = 2'd0;
            rptr_n = 1'b0;
            wptr_n = 1'b0;
        end
        // Head is a register loaded with next cycle's head entry. When the
        // slot being written is also the next head (empty, or single entry
        // replaced by push+pop), it must come from the incoming data rather
        // than the stale storage. When the buffer goes empty the head holds.
        if (cnt_n != 2'd0)
            head_n = (push && (wptr == rptr_n)) ? in_e : mem[rptr_n];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            count  <= 2'd0;
            flags  <= 4'b0000;
            ops    <= 16'd0;
        end else begin
            if (push)
                mem[wptr] <= in_e;
            head  <= head_n;
            rptr  <= rptr_n;
            wptr  <= wptr_n;
            count <= cnt_n;
            if (push && bus.FlagWrite)
                flags <= {bus.Result[WIDTH-1], bus.Zero, bus.CarryOut, bus.Overflow};
            if (pop)
                ops <= ops + 16'd1;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_result_if #(.WIDTH(16), .REG_BITS(3)) bus ();

    alu_result_stage #(.WIDTH(16), .REG_BITS(3)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic z,
                         input logic o, input logic c, input logic [2:0] d,
                         input logic rw, input logic fw);
        bus.InValid = v; bus.Result = r; bus.Zero = z; bus.Overflow = o;
        bus.CarryOut = c; bus.RegDst = d; bus.RegWrite = rw; bus.FlagWrite = fw;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ovalid"}, 32'(bus.OutValid), 32'd0);
        chk({tag, "_iready"}, 32'(bus.InReady), 32'd1);
        chk({tag, "_odata"}, 32'(bus.OutData), 32'h0);
        chk({tag, "_odst"}, 32'(bus.OutRegDst), 32'd0);
        chk({tag, "_orw"}, 32'(bus.OutRegWrite), 32'd0);
        chk({tag, "_flags"}, 32'(bus.Flags), 32'h0);
        chk({tag, "_ops"}, 32'(bus.OpCount), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        bus.Flush = 0; bus.OutReady = 0;
        step(); step();
        rst = 1'b0;
        chk_reset_vals("rst");

        // First push: 8001 -> N=1, C=1
        bus.OutReady = 1;
        drive(1, 16'h8001, 0, 0, 1, 3'd3, 1, 1);
        step();
        chk("p1_valid", 32'(bus.OutValid), 32'd1);
        chk("p1_data", 32'(bus.OutData), 32'h8001);
        chk("p1_dst", 32'(bus.OutRegDst), 32'd3);
        chk("p1_rw", 32'(bus.OutRegWrite), 32'd1);
        chk("p1_flags", 32'(bus.Flags), 32'b1010);
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        step();
        chk("p1_ops", 32'(bus.OpCount), 32'd1);
        chk("p1_empty", 32'(bus.OutValid), 32'd0);

        // Fill to full with writeback stalled
        bus.OutReady = 0;
        drive(1, 16'h0001, 0, 0, 0, 3'd1, 1, 0); step();
        drive(1, 16'h0002, 0, 0, 0, 3'd2, 0, 0); step();
        chk("full_iready", 32'(bus.InReady), 32'd0);
        chk("full_ovalid", 32'(bus.OutValid), 32'd1);
        drive(1, 16'h0003, 0, 0, 0, 3'd3, 1, 0); step();   // ignored
        chk("full_head", 32'(bus.OutData), 32'h0001);
        chk("full_iready2", 32'(bus.InReady), 32'd0);
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        bus.OutReady = 1;
        step();
        chk("drain_head2", 32'(bus.OutData), 32'h0002);
        chk("drain_dst2", 32'(bus.OutRegDst), 32'd2);
        chk("drain_rw2", 32'(bus.OutRegWrite), 32'd0);
        chk("drain_iready", 32'(bus.InReady), 32'd1);
        step();
        chk("drain_empty", 32'(bus.OutValid), 32'd0);
        chk("drain_ops", 32'(bus.OpCount), 32'd3);

        // Streaming at occupancy 1: push and pop every cycle
        for (int i = 1; i <= 10; i++) begin
            bus.OutReady = (i > 1);
            drive(1, 16'(i), 0, 0, 0, 3'(i), 1, 0);
            step();
            chk("strm_data", 32'(bus.OutData), 32'(i));
            chk("strm_occ", {30'd0, bus.OutValid, bus.InReady}, 32'b11);
        end
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        step();
        chk("strm_ops", 32'(bus.OpCount), 32'd13);
        chk("strm_empty", 32'(bus.OutValid), 32'd0);

        // FlagWrite=0 leaves flags alone
        drive(1, 16'h0000, 1, 0, 0, 3'd0, 1, 0); step();
        chk("fw0_flags", 32'(bus.Flags), 32'b1010);
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0); step();
        drive(1, 16'h0000, 1, 1, 0, 3'd0, 1, 1); step();
        chk("fw1_flags", 32'(bus.Flags), 32'b0101);
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0); step();
        chk("fl_ops", 32'(bus.OpCount), 32'd15);

        // Flush with two entries, plus InValid and OutReady
        bus.OutReady = 0;
        drive(1, 16'h00AA, 0, 0, 0, 3'd1, 1, 0); step();
        drive(1, 16'h00BB, 0, 0, 0, 3'd2, 1, 0); step();
        chk("pre_flush_full", 32'(bus.InReady), 32'd0);
        drive(1, 16'hFFFF, 0, 0, 1, 3'd7, 1, 1);
        bus.Flush = 1; bus.OutReady = 1;
        step();
        bus.Flush = 0;
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        chk("flush_ovalid", 32'(bus.OutValid), 32'd0);
        chk("flush_iready", 32'(bus.InReady), 32'd1);
        chk("flush_ops", 32'(bus.OpCount), 32'd16);
        chk("flush_flags", 32'(bus.Flags), 32'b0101);

        // Flush at occupancy 1: push would be accepted but is dropped
        bus.OutReady = 0;
        drive(1, 16'h00CC, 0, 0, 0, 3'd1, 1, 0); step();
        drive(1, 16'h8000, 0, 0, 1, 3'd4, 1, 1);
        bus.Flush = 1;
        step();
        bus.Flush = 0;
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        chk("flush1_ovalid", 32'(bus.OutValid), 32'd0);
        chk("flush1_flags", 32'(bus.Flags), 32'b0101);
        chk("flush1_ops", 32'(bus.OpCount), 32'd16);
        step();
        chk("flush1_stay", 32'(bus.OutValid), 32'd0);

        // Reset with two entries buffered
        drive(1, 16'h8000, 0, 0, 0, 3'd5, 1, 1); step();
        chk("mid_flags", 32'(bus.Flags), 32'b1000);
        drive(1, 16'h1234, 0, 0, 0, 3'd6, 1, 0); step();
        chk("mid_full", 32'(bus.InReady), 32'd0);
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrst");

        // OpCount wrap: first step is a push only, then push+pop each cycle
        bus.OutReady = 1;
        drive(1, 16'h0055, 0, 0, 0, 3'd1, 1, 0);
        for (int i = 0; i < 65536; i++) step();
        chk("wrap_ffff", 32'(bus.OpCount), 32'h0000FFFF);
        step();
        chk("wrap_zero", 32'(bus.OpCount), 32'd0);
        drive(0, 16'h0, 0, 0, 0, 3'd0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
